// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: tracks in-flight destinations in EX/MEM/WB, stalls ID on RAW,
// freezes on memory busy, flushes IF/ID on taken branches and keeps stall statistics.
module hazard_stall_ctrl #(
  parameter bit WB_RESOLVED = 1'b1,
  parameter int MAX_STALL   = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_reg_dest_i,
  input  logic             id_reg_write_i,
  input  logic             id_uses_rs_i,
  input  logic             id_uses_rt_i,
  input  logic             mem_busy_i,
  input  logic             flush_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_en_o,
  output logic             id_ex_bubble_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             hazard_stall_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             stall_timeout_o
);
  localparam int CW = $clog2(MAX_STALL + 1);

  typedef struct packed {
    logic       vld;
    logic       rw;
    logic [4:0] dest;
  } slot_t;

  typedef enum logic [1:0] {RUN, RAW, FLUSH, FREEZE} mode_e;

  slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_slot;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]    consec_q, consec_d;
  logic             timeout_q, timeout_d;
  logic             rs_hit, rt_hit, raw, stall;
  mode_e            mode;

  function automatic logic hit(input slot_t s, input logic [4:0] r);
    return s.vld && s.rw && (s.dest == r) && (r != 5'd0);
  endfunction

  assign id_slot = {id_valid_i, id_reg_write_i, id_reg_dest_i ? id_rd_i : id_rt_i};
  assign rs_hit  = hit(ex_q, id_rs_i) || hit(mem_q, id_rs_i) || (!WB_RESOLVED && hit(wb_q, id_rs_i));
  assign rt_hit  = hit(ex_q, id_rt_i) || hit(mem_q, id_rt_i) || (!WB_RESOLVED && hit(wb_q, id_rt_i));
  assign raw     = id_valid_i && ((id_uses_rs_i && rs_hit) || (id_uses_rt_i && rt_hit));

  always_comb begin
    mode = RUN;
    if (mem_busy_i)   mode = FREEZE;
    else if (flush_i) mode = FLUSH;
    else if (raw)     mode = RAW;
  end

  // Controls are forced low while reset is held, independent of the decoded mode.
  always_comb begin
    pc_en_o        = 1'b0;
    if_id_en_o     = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_en_o     = 1'b0;
    id_ex_bubble_o = 1'b0;
    ex_mem_en_o    = 1'b0;
    mem_wb_en_o    = 1'b0;
    hazard_stall_o = 1'b0;
    if (rst_ni) begin
      case (mode)
        RUN: begin
          pc_en_o     = 1'b1;
          if_id_en_o  = 1'b1;
          id_ex_en_o  = 1'b1;
          ex_mem_en_o = 1'b1;
          mem_wb_en_o = 1'b1;
        end
        RAW: begin
          id_ex_en_o     = 1'b1;
          id_ex_bubble_o = 1'b1;
          ex_mem_en_o    = 1'b1;
          mem_wb_en_o    = 1'b1;
          hazard_stall_o = 1'b1;
        end
        FLUSH: begin
          pc_en_o        = 1'b1;
          if_id_en_o     = 1'b1;
          if_id_flush_o  = 1'b1;
          id_ex_en_o     = 1'b1;
          id_ex_bubble_o = 1'b1;
          ex_mem_en_o    = 1'b1;
          mem_wb_en_o    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (mode != FREEZE) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = (mode == RUN) ? id_slot : '0;
    end
    stall = (mode == FREEZE) || (mode == RAW);
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    consec_d = '0;
    if (stall) consec_d = (consec_q == CW'(MAX_STALL)) ? consec_q : consec_q + CW'(1);
    timeout_d = timeout_q || (consec_d == CW'(MAX_STALL));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      cnt_q     <= '0;
      consec_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      cnt_q     <= cnt_d;
      consec_q  <= consec_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_cnt_o     = cnt_q;
  assign stall_timeout_o = timeout_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three configurations share stimulus and are compared every cycle
// against an instruction-history model; directed scenarios add fixed expectations.
module tb_hazard_stall_ctrl;
  logic       clk, rst_n;
  logic       id_valid, id_reg_dest, id_reg_write, id_uses_rs, id_uses_rt, mem_busy, flush;
  logic [4:0] id_rs, id_rt, id_rd;

  logic pc_en[3], if_id_en[3], if_id_flush[3], id_ex_en[3], id_ex_bubble[3];
  logic ex_mem_en[3], mem_wb_en[3], hazard_stall[3], stall_timeout[3];
  logic [15:0] cnt0, cnt2;
  logic [3:0]  cnt1;

  int n_pass = 0, n_total = 0;

  hazard_stall_ctrl u0 (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_rd_i(id_rd), .id_reg_dest_i(id_reg_dest), .id_reg_write_i(id_reg_write),
    .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt), .mem_busy_i(mem_busy), .flush_i(flush),
    .pc_en_o(pc_en[0]), .if_id_en_o(if_id_en[0]), .if_id_flush_o(if_id_flush[0]),
    .id_ex_en_o(id_ex_en[0]), .id_ex_bubble_o(id_ex_bubble[0]), .ex_mem_en_o(ex_mem_en[0]),
    .mem_wb_en_o(mem_wb_en[0]), .hazard_stall_o(hazard_stall[0]), .stall_cnt_o(cnt0),
    .stall_timeout_o(stall_timeout[0]));

  hazard_stall_ctrl #(.MAX_STALL(4), .CNT_W(4)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_rd_i(id_rd), .id_reg_dest_i(id_reg_dest), .id_reg_write_i(id_reg_write),
    .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt), .mem_busy_i(mem_busy), .flush_i(flush),
    .pc_en_o(pc_en[1]), .if_id_en_o(if_id_en[1]), .if_id_flush_o(if_id_flush[1]),
    .id_ex_en_o(id_ex_en[1]), .id_ex_bubble_o(id_ex_bubble[1]), .ex_mem_en_o(ex_mem_en[1]),
    .mem_wb_en_o(mem_wb_en[1]), .hazard_stall_o(hazard_stall[1]), .stall_cnt_o(cnt1),
    .stall_timeout_o(stall_timeout[1]));

  hazard_stall_ctrl #(.WB_RESOLVED(1'b0)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_rd_i(id_rd), .id_reg_dest_i(id_reg_dest), .id_reg_write_i(id_reg_write),
    .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt), .mem_busy_i(mem_busy), .flush_i(flush),
    .pc_en_o(pc_en[2]), .if_id_en_o(if_id_en[2]), .if_id_flush_o(if_id_flush[2]),
    .id_ex_en_o(id_ex_en[2]), .id_ex_bubble_o(id_ex_bubble[2]), .ex_mem_en_o(ex_mem_en[2]),
    .mem_wb_en_o(mem_wb_en[2]), .hazard_stall_o(hazard_stall[2]), .stall_cnt_o(cnt2),
    .stall_timeout_o(stall_timeout[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the last three issued pipeline entries, youngest first (index 0 = EX).
  typedef struct {bit v; bit rw; int dest;} ent_t;
  ent_t hist[3][$];
  int   m_cnt[3], m_consec[3];
  bit   m_to[3];
  int   MAXS[3] = '{64, 4, 64};
  int   MAXC[3] = '{65535, 15, 65535};
  int   NCHK[3] = '{2, 2, 3};

  function automatic void m_reset();
    ent_t e = '{0, 0, 0};
    for (int i = 0; i < 3; i++) begin
      hist[i].delete();
      for (int k = 0; k < 3; k++) hist[i].push_back(e);
      m_cnt[i] = 0; m_consec[i] = 0; m_to[i] = 0;
    end
  endfunction

  function automatic bit dep(int i, int r);
    if (r == 0) return 0;
    for (int k = 0; k < NCHK[i]; k++)
      if (hist[i][k].v && hist[i][k].rw && hist[i][k].dest == r) return 1;
    return 0;
  endfunction

  // 3 = freeze, 2 = flush, 1 = raw, 0 = run
  function automatic int mode_of(int i);
    if (mem_busy) return 3;
    if (flush) return 2;
    if (id_valid && ((id_uses_rs && dep(i, int'(id_rs))) || (id_uses_rt && dep(i, int'(id_rt)))))
      return 1;
    return 0;
  endfunction

  // bit order: pc, if_id_en, if_id_flush, id_ex_en, bubble, ex_mem, mem_wb, hazard
  function automatic logic [7:0] exp_ctl(int i);
    if (!rst_n) return 8'h00;
    case (mode_of(i))
      3: return 8'b0000_0000;
      2: return 8'b1111_1110;
      1: return 8'b0001_1111;
      default: return 8'b1101_0110;
    endcase
  endfunction

  function automatic logic [7:0] obs_ctl(int i);
    return {pc_en[i], if_id_en[i], if_id_flush[i], id_ex_en[i], id_ex_bubble[i],
            ex_mem_en[i], mem_wb_en[i], hazard_stall[i]};
  endfunction

  function automatic int obs_cnt(int i);
    if (i == 0) return int'(cnt0);
    if (i == 1) return int'(cnt1);
    return int'(cnt2);
  endfunction

  task automatic check_model(string tag);
    #1;
    if (!rst_n) m_reset();
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (obs_ctl(i) !== exp_ctl(i))
        $display("FAIL %s ctl[u%0d] got=%b exp=%b t=%0t", tag, i, obs_ctl(i), exp_ctl(i), $time);
      else n_pass++;
      n_total++;
      if (obs_cnt(i) != m_cnt[i])
        $display("FAIL %s stall_cnt[u%0d] got=%0d exp=%0d", tag, i, obs_cnt(i), m_cnt[i]);
      else n_pass++;
      n_total++;
      if (stall_timeout[i] !== m_to[i])
        $display("FAIL %s timeout[u%0d] got=%b exp=%b", tag, i, stall_timeout[i], m_to[i]);
      else n_pass++;
    end
  endtask

  task automatic advance();
    int   md[3];
    ent_t e, drop;
    for (int i = 0; i < 3; i++) md[i] = mode_of(i);
    @(posedge clk);
    if (!rst_n) m_reset();
    else for (int i = 0; i < 3; i++) begin
      if (md[i] != 3) begin
        if (md[i] == 0) e = '{id_valid, id_reg_write, id_reg_dest ? int'(id_rd) : int'(id_rt)};
        else e = '{0, 0, 0};
        hist[i].push_front(e);
        drop = hist[i].pop_back();
      end
      if (md[i] == 3 || md[i] == 1) begin
        if (m_cnt[i] < MAXC[i]) m_cnt[i]++;
        m_consec[i]++;
        if (m_consec[i] >= MAXS[i]) m_to[i] = 1;
      end else m_consec[i] = 0;
    end
    @(negedge clk);
  endtask

  task automatic set_instr(bit v, int rs, int rt, int rd, bit rdest, bit wr, bit urs, bit urt);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
    id_reg_dest = rdest; id_reg_write = wr; id_uses_rs = urs; id_uses_rt = urt;
  endtask

  task automatic reset_dut();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    mem_busy = 0; flush = 0;
    @(negedge clk);
    rst_n = 0;
    check_model("reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    m_reset();
  endtask

  task automatic test_reset();
    reset_dut();
    check_model("post_reset");
    n_total++;
    if (obs_ctl(0) !== 8'b1101_0110) $display("FAIL first_run_ctl got=%b exp=11010110", obs_ctl(0));
    else n_pass++;
    advance();
  endtask

  task automatic test_back_to_back();
    int hz = 0;
    reset_dut();
    set_instr(1, 0, 0, 3, 1, 1, 0, 0);
    check_model("b2b_prod"); advance();
    set_instr(1, 3, 4, 5, 1, 1, 1, 0);
    for (int c = 0; c < 4; c++) begin
      check_model("b2b_cons");
      if (hazard_stall[0] === 1'b1) begin
        hz++;
        n_total++;
        if (pc_en[0] !== 1'b0 || id_ex_bubble[0] !== 1'b1)
          $display("FAIL b2b_stall_ctl pc_en=%b bubble=%b exp pc_en=0 bubble=1", pc_en[0], id_ex_bubble[0]);
        else n_pass++;
      end
      advance();
    end
    n_total++;
    if (hz != 2) $display("FAIL b2b_stall_cycles got=%0d exp=2", hz); else n_pass++;
    n_total++;
    if (cnt0 !== 16'd2) $display("FAIL b2b_stall_cnt got=%0d exp=2", cnt0); else n_pass++;
  endtask

  task automatic test_zero_regdest();
    reset_dut();
    set_instr(1, 0, 0, 9, 0, 1, 0, 0);
    check_model("zero_prod"); advance();
    set_instr(1, 0, 0, 4, 1, 1, 1, 1);
    check_model("zero_cons");
    n_total++;
    if (hazard_stall[0] !== 1'b0) $display("FAIL zero_no_stall got=%b exp=0", hazard_stall[0]); else n_pass++;
    advance();
    set_instr(1, 0, 7, 9, 0, 1, 0, 0);
    check_model("rt_prod"); advance();
    set_instr(1, 1, 7, 2, 1, 1, 0, 1);
    check_model("rt_cons");
    n_total++;
    if (hazard_stall[0] !== 1'b1) $display("FAIL regdest_rt_stall got=%b exp=1", hazard_stall[0]); else n_pass++;
    advance();
  endtask

  task automatic test_freeze();
    reset_dut();
    set_instr(1, 0, 0, 3, 1, 1, 0, 0);
    check_model("frz_prod"); advance();
    set_instr(1, 3, 0, 5, 1, 1, 1, 0);
    check_model("frz_raw1"); advance();
    mem_busy = 1;
    for (int c = 0; c < 3; c++) begin
      check_model("frz_hold");
      n_total++;
      if (obs_ctl(0) !== 8'h00) $display("FAIL freeze_ctl got=%b exp=00000000", obs_ctl(0)); else n_pass++;
      advance();
    end
    mem_busy = 0;
    check_model("frz_raw2");
    n_total++;
    if (hazard_stall[0] !== 1'b1) $display("FAIL freeze_raw_resume got=%b exp=1", hazard_stall[0]); else n_pass++;
    advance();
    check_model("frz_done");
    n_total++;
    if (pc_en[0] !== 1'b1) $display("FAIL freeze_resolved pc_en got=%b exp=1", pc_en[0]); else n_pass++;
    n_total++;
    if (cnt0 !== 16'd5) $display("FAIL freeze_stall_cnt got=%0d exp=5", cnt0); else n_pass++;
    advance();
  endtask

  task automatic test_flush();
    reset_dut();
    set_instr(1, 0, 0, 3, 1, 1, 0, 0);
    check_model("fl_prod"); advance();
    set_instr(1, 3, 0, 5, 1, 1, 1, 0);
    flush = 1;
    check_model("fl_cons");
    n_total++;
    if (obs_ctl(0) !== 8'b1111_1110) $display("FAIL flush_priority got=%b exp=11111110", obs_ctl(0));
    else n_pass++;
    advance();
    flush = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    check_model("fl_after");
    n_total++;
    if (cnt0 !== 16'd0) $display("FAIL flush_stall_cnt got=%0d exp=0", cnt0); else n_pass++;
    advance();
  endtask

  task automatic test_watchdog();
    reset_dut();
    mem_busy = 1;
    for (int c = 1; c <= 20; c++) begin
      check_model("wd_busy"); advance();
      if (c == 3 || c == 4) begin
        n_total++;
        if (stall_timeout[1] !== (c == 4))
          $display("FAIL watchdog_edge after=%0d got=%b exp=%b", c, stall_timeout[1], c == 4);
        else n_pass++;
      end
    end
    mem_busy = 0;
    for (int c = 0; c < 3; c++) begin check_model("wd_idle"); advance(); end
    n_total++;
    if (stall_timeout[1] !== 1'b1) $display("FAIL watchdog_sticky got=%b exp=1", stall_timeout[1]); else n_pass++;
    n_total++;
    if (cnt1 !== 4'd15) $display("FAIL cnt_saturate got=%0d exp=15", cnt1); else n_pass++;
    n_total++;
    if (cnt0 !== 16'd20 || stall_timeout[0] !== 1'b0)
      $display("FAIL wide_cnt got=%0d/%b exp=20/0", cnt0, stall_timeout[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    reset_dut();
    set_instr(1, 0, 0, 3, 1, 1, 0, 0);
    check_model("mr_prod"); advance();
    set_instr(1, 3, 0, 5, 1, 1, 1, 0);
    check_model("mr_raw");
    #1 rst_n = 0;
    check_model("mr_in_reset");
    n_total++;
    if (pc_en[0] !== 1'b0 || id_ex_en[0] !== 1'b0 || hazard_stall[0] !== 1'b0)
      $display("FAIL midreset_outputs pc=%b idex=%b hz=%b exp 0", pc_en[0], id_ex_en[0], hazard_stall[0]);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    check_model("mr_release");
    n_total++;
    if (hazard_stall[0] !== 1'b0 || pc_en[0] !== 1'b1 || cnt0 !== 16'd0)
      $display("FAIL midreset_flow hz=%b pc=%b cnt=%0d exp 0/1/0", hazard_stall[0], pc_en[0], cnt0);
    else n_pass++;
    advance();
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 800; c++) begin
      set_instr($urandom_range(0, 3) != 0, $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 4), $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      mem_busy = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) rst_n = 0;
      check_model("random");
      advance();
      rst_n = 1;
    end
  endtask

  initial begin
    rst_n = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    mem_busy = 0; flush = 0;
    m_reset();
    test_reset();
    test_back_to_back();
    test_zero_regdest();
    test_freeze();
    test_flush();
    test_watchdog();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
